// File: rtl/filter_storage_reader.sv
`default_nettype none
// ============================================================================
//  Module   : filter_storage_reader
//  Purpose  : Read-side sequencer for the filter coefficient/sample RAM.
//             Walks a wrapping address window, absorbs the RAM's one-cycle
//             registered read latency and streams the words out on a
//             ready/valid interface without ever dropping a word.
//  Revision : 1.0  initial release
// ============================================================================
module filter_storage_reader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_ptr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              rden,
    output logic [ADDR_W-1:0] rdptr,
    input  logic [DATA_W-1:0] rddata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int CNT_W = ADDR_W + 1;

    // Word storage: the presented output word plus a two-deep skid, kept as
    // one 3-slot circular buffer. Issuing is throttled so that buffered words
    // plus reads still in the RAM pipeline never exceed the slot count.
    localparam logic [2:0] c_slots = 3'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [CNT_W-1:0]    r_remaining;
    logic [CNT_W-1:0]    r_deliv;
    logic                r_rden;
    logic [ADDR_W-1:0]   r_rdptr;
    logic                r_cap;
    logic                r_done;
    logic [DATA_W-1:0]   r_mem [3];
    logic [1:0]          r_wp;
    logic [1:0]          r_rp;
    logic [1:0]          r_cnt;

    logic                w_pop;
    logic                w_issue;
    logic                w_load;
    logic                w_done_nxt;
    logic [ADDR_W-1:0]   w_issue_addr;
    logic [2:0]          w_committed;

    function automatic logic [1:0] f_inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign out_valid = (r_cnt != 2'd0);
    assign out_data  = r_mem[r_rp];
    assign out_last  = out_valid && (r_deliv == CNT_W'(1));
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign rden      = r_rden;
    assign rdptr     = r_rdptr;

    assign w_pop       = out_valid && out_ready;
    // Words already owned by this block: stored, on the RAM data bus, or
    // being sampled by the RAM this cycle, minus the one leaving now.
    assign w_committed = {1'b0, r_cnt} + {2'b0, r_cap} + {2'b0, r_rden} - {2'b0, w_pop};

    // Next-state, read-issue and completion decisions.
    always_comb begin
        w_state_nxt  = r_state;
        w_issue      = 1'b0;
        w_load       = 1'b0;
        w_done_nxt   = 1'b0;
        w_issue_addr = r_rd_addr;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        // First read goes out on the same edge that accepts start.
                        w_load       = 1'b1;
                        w_issue      = 1'b1;
                        w_issue_addr = base_ptr;
                        w_state_nxt  = (length == CNT_W'(1)) ? S_DRAIN : S_RUN;
                    end
                end
            end
            S_RUN: begin
                if ((r_remaining != '0) && (w_committed < c_slots)) begin
                    w_issue = 1'b1;
                    if (r_remaining == CNT_W'(1)) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_pop && (r_deliv == CNT_W'(1))) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Address walk, window counters, RAM port and read-return tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_addr   <= '0;
            r_remaining <= '0;
            r_deliv     <= '0;
            r_rden      <= 1'b0;
            r_rdptr     <= '0;
            r_cap       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_rden <= w_issue;
            r_cap  <= r_rden;
            r_done <= w_done_nxt;
            if (w_issue) begin
                r_rdptr   <= w_issue_addr;
                r_rd_addr <= w_issue_addr + ADDR_W'(1);
            end
            if (w_load) begin
                r_remaining <= length - CNT_W'(1);
                r_deliv     <= length;
            end else begin
                if (w_issue) begin
                    r_remaining <= r_remaining - CNT_W'(1);
                end
                if (w_pop) begin
                    r_deliv <= r_deliv - CNT_W'(1);
                end
            end
        end
    end

    // Circular word buffer: capture returning RAM data, release on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                r_mem[i] <= '0;
            end
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (r_cap) begin
                r_mem[r_wp] <= rddata;
                r_wp        <= f_inc3(r_wp);
            end
            if (w_pop) begin
                r_rp <= f_inc3(r_rp);
            end
            case ({r_cap, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule
`default_nettype wire
